// File: rtl/block_memory.sv
// Line-granular main memory: one line per request, moved in BEAT_BYTES beats after ACCESS_LATENCY idle cycles.
// busywait is high for ACCESS_LATENCY+BEATS cycles; a request held past completion is ignored for one DONE cycle.
module block_memory #(
  parameter int    ADDR_WIDTH     = 28,
  parameter int    LINE_BYTES     = 16,
  parameter int    BEAT_BYTES     = 1,
  parameter int    MEM_BYTES      = 1024,
  parameter int    ACCESS_LATENCY = 0,
  parameter string INIT_FILE      = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [LINE_BYTES*8-1:0] writedata,
  output logic [LINE_BYTES*8-1:0] readdata,
  output logic                    busywait
);

  localparam int BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int OFFW  = $clog2(LINE_BYTES);
  localparam int BAW   = ADDR_WIDTH + OFFW;
  localparam int MW    = $clog2(MEM_BYTES);
  localparam int LW    = LINE_BYTES * 8;
  localparam int LIW   = $clog2(LW);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, LAT, XFER, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic [BCW-1:0]      beat_q, beat_d;
  logic                busy_q, busy_d;
  logic                wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]       wdata_q;
  logic [LW-1:0]       rdata_q;
  logic                accept;
  logic                beat_en;
  logic                last_beat;

  logic [7:0]          mem [MEM_BYTES];
  logic [BAW-1:0]      line_base;
  logic [MW-1:0]       mem_idx  [BEAT_BYTES];
  logic [LIW-1:0]      lane_bit [BEAT_BYTES];

  // Byte addresses wrap modulo MEM_BYTES by truncating to MW bits.
  always_comb begin
    line_base = BAW'(addr_q) << OFFW;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      mem_idx[i]  = MW'(line_base + BAW'(beat_q) * BAW'(BEAT_BYTES) + BAW'(i));
      lane_bit[i] = LIW'((int'(beat_q) * BEAT_BYTES + i) * 8);
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    accept    = 1'b0;
    beat_en   = 1'b0;
    last_beat = (beat_q == BCW'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          lat_d   = 4'(ACCESS_LATENCY);
          beat_d  = '0;
          state_d = (ACCESS_LATENCY > 0) ? LAT : XFER;
        end
      end
      LAT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) state_d = XFER;
      end
      XFER: begin
        beat_en = 1'b1;
        if (last_beat) begin
          busy_d  = 1'b0;
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + BCW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      if (accept) begin
        wr_q    <= write;
        addr_q  <= address;
        wdata_q <= writedata;
      end
      if (beat_en && !wr_q) begin
        for (int i = 0; i < BEAT_BYTES; i++) begin
          rdata_q[lane_bit[i] +: 8] <= mem[mem_idx[i]];
        end
      end
    end
  end

  // Storage is deliberately outside reset; beat_en is already forced low while reset holds.
  always_ff @(posedge clock) begin
    if (beat_en && wr_q) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        mem[mem_idx[i]] <= wdata_q[lane_bit[i] +: 8];
      end
    end
  end

  assign readdata = rdata_q;
  assign busywait = busy_q;

endmodule

// File: tb/tb_block_memory.sv
// Two block_memory instances (defaults; latency 3 with 4-byte beats) share stimulus and are checked every cycle
// against a per-instance line-level model, plus literal expectations for the headline scenarios.
module tb_block_memory;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         read  = 1'b0;
  logic         write = 1'b0;
  logic [27:0]  address   = '0;
  logic [127:0] writedata = '0;
  logic         busy_w [2];
  logic [127:0] rd_w   [2];

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;
  int hist [2][40];
  int cnt  [2];

  // Line-level model state, one set per instance.
  bit           m_active [2];
  bit           m_is_rd  [2];
  int           m_c      [2];
  logic [127:0] m_old    [2];
  logic [127:0] m_new    [2];
  logic [7:0]   mmem     [2][1024];

  always #5 clock = ~clock;

  block_memory #(.ADDR_WIDTH(28), .LINE_BYTES(16), .BEAT_BYTES(1), .MEM_BYTES(1024),
                 .ACCESS_LATENCY(0), .INIT_FILE("")) dut_a (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(rd_w[0]), .busywait(busy_w[0]));

  block_memory #(.ADDR_WIDTH(28), .LINE_BYTES(16), .BEAT_BYTES(4), .MEM_BYTES(1024),
                 .ACCESS_LATENCY(3), .INIT_FILE("")) dut_b (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(rd_w[1]), .busywait(busy_w[1]));

  function automatic int lat_of(input int j);   return (j == 0) ? 0 : 3;  endfunction
  function automatic int beats_of(input int j); return (j == 0) ? 16 : 4; endfunction
  function automatic int bb_of(input int j);    return (j == 0) ? 1 : 4;  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_step(input int j);
    int n;
    int base;
    n = lat_of(j) + beats_of(j);
    if ((!m_active[j] || m_c[j] >= n + 2) && (read || write)) begin
      if (m_active[j] && m_is_rd[j]) m_old[j] = m_new[j];
      m_active[j] = 1'b1;
      m_c[j] = 1;
      base = int'(address % 28'd64) * 16;
      if (write) begin
        for (int b = 0; b < 16; b++) mmem[j][base + b] = writedata[8*b +: 8];
        m_is_rd[j] = 1'b0;
      end else begin
        for (int b = 0; b < 16; b++) m_new[j][8*b +: 8] = mmem[j][base + b];
        m_is_rd[j] = 1'b1;
      end
    end else if (m_active[j]) begin
      if (m_c[j] >= n + 2) begin
        if (m_is_rd[j]) m_old[j] = m_new[j];
        m_active[j] = 1'b0;
        m_is_rd[j]  = 1'b0;
      end else begin
        m_c[j]++;
      end
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < 2; j++) begin
        m_active[j] = 1'b0;
        m_is_rd[j]  = 1'b0;
        m_c[j]      = 0;
        m_old[j]    = '0;
        m_new[j]    = '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) model_step(j);
    end
  end

  function automatic logic exp_busy(input int j);
    return m_active[j] && (m_c[j] <= lat_of(j) + beats_of(j));
  endfunction

  function automatic logic [127:0] exp_rd(input int j);
    logic [127:0] r;
    int bd;
    r = m_old[j];
    if (m_active[j] && m_is_rd[j]) begin
      bd = m_c[j] - 1 - lat_of(j);
      if (bd < 0) bd = 0;
      if (bd > beats_of(j)) bd = beats_of(j);
      for (int b = 0; b < bd * bb_of(j); b++) r[8*b +: 8] = m_new[j][8*b +: 8];
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("busywait[%0d]", j), busy_w[j], exp_busy(j));
        check($sformatf("readdata[%0d]", j), rd_w[j], exp_rd(j));
      end
    end
  end

  // Called at a negedge with both instances idle; fixed 40-cycle window per operation.
  task automatic run_op(input bit rd, input bit wr, input logic [27:0] a,
                        input logic [127:0] wd, input int hold);
    read = rd; write = wr; address = a; writedata = wd;
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k == hold - 1) begin
        read = 1'b0; write = 1'b0;
        address   = 28'($urandom);
        writedata = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int j = 0; j < 2; j++) begin
        hist[j][k] = int'(busy_w[j]);
        cnt[j] += int'(busy_w[j]);
      end
    end
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] LINE0 = 128'h3e800093;
  localparam logic [127:0] D1    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2    = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("reset busywait[%0d]", j), busy_w[j], 1'b0);
      check($sformatf("reset readdata[%0d]", j), rd_w[j], 128'h0);
    end
    #2 reset = 1'b1;
    @(negedge clock);
    cmp_en = 1'b1;

    for (int i = 0; i < 64; i++) run_op(1'b0, 1'b1, 28'(i), rnd_line(), 1);

    run_op(1'b0, 1'b1, 28'd0, LINE0, 1);
    run_op(1'b1, 1'b0, 28'd0, '0, 1);
    check("read0 cycles[0]", 128'(cnt[0]), 128'd16);
    check("read0 cycles[1]", 128'(cnt[1]), 128'd7);
    check("read0 data[0]", rd_w[0], LINE0);
    check("read0 data[1]", rd_w[1], LINE0);

    run_op(1'b0, 1'b1, 28'd3, D1, 1);
    check("write3 cycles[0]", 128'(cnt[0]), 128'd16);
    check("write keeps readdata", rd_w[0], LINE0);
    run_op(1'b1, 1'b0, 28'd3, '0, 1);
    check("read3 data[0]", rd_w[0], D1);
    check("read3 data[1]", rd_w[1], D1);

    run_op(1'b1, 1'b0, 28'd64, '0, 1);
    check("wrap 64 data[0]", rd_w[0], LINE0);
    run_op(1'b1, 1'b0, 28'hFFFFFC3, '0, 1);
    check("wrap high data[1]", rd_w[1], D1);

    run_op(1'b1, 1'b1, 28'd5, D2, 1);
    check("rw both readdata[0]", rd_w[0], D1);
    check("rw both readdata[1]", rd_w[1], D1);
    run_op(1'b1, 1'b0, 28'd5, '0, 1);
    check("rw both wrote[0]", rd_w[0], D2);

    run_op(1'b1, 1'b0, 28'd0, '0, 20);
    check("held a last busy", 128'(hist[0][15]), 128'd1);
    check("held a done low",  128'(hist[0][16]), 128'd0);
    check("held a idle low",  128'(hist[0][17]), 128'd0);
    check("held a restart",   128'(hist[0][18]), 128'd1);
    check("held b last busy", 128'(hist[1][6]), 128'd1);
    check("held b done low",  128'(hist[1][7]), 128'd0);
    check("held b idle low",  128'(hist[1][8]), 128'd0);
    check("held b restart",   128'(hist[1][9]), 128'd1);

    read = 1'b1; address = 28'd3;
    @(negedge clock);
    read = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("midreset busywait[%0d]", j), busy_w[j], 1'b0);
      check($sformatf("midreset readdata[%0d]", j), rd_w[j], 128'h0);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    run_op(1'b1, 1'b0, 28'd3, '0, 1);
    check("post reset cycles[0]", 128'(cnt[0]), 128'd16);
    check("post reset data[0]", rd_w[0], D1);

    for (int n = 0; n < 80; n++) begin
      int sel;
      logic [27:0] a;
      sel = $urandom_range(0, 9);
      a = ($urandom_range(0, 1) == 0) ? 28'($urandom_range(0, 130)) : 28'($urandom);
      if (sel < 4)       run_op(1'b1, 1'b0, a, rnd_line(), 1);
      else if (sel < 8)  run_op(1'b0, 1'b1, a, rnd_line(), 1);
      else if (sel == 8) run_op(1'b1, 1'b1, a, rnd_line(), 1);
      else               run_op(1'b1, 1'b0, a, rnd_line(), $urandom_range(2, 20));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
